// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: CPU port 0 and loader/debug port 1 share one single-cycle memory.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin contention; default build uses fixed priority to port 0.
module mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic              p1_lock,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHARED = 2'd1;
  localparam logic [1:0] S_LOCK1  = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic              w_p0_wins;
  logic              r_p0_rd_pend;
  logic              r_p1_rd_pend;
  logic [DATA_W-1:0] r_p0_rdata;
  logic [DATA_W-1:0] r_p1_rdata;
  logic              w_p0_rvalid;
  logic              w_p1_rvalid;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic r_last_p1;

  // Reset value 1 makes the first contention after reset go to port 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_p1 <= 1'b1;
    end else if (p0_gnt || p1_gnt) begin
      r_last_p1 <= p1_gnt;
    end
  end

  assign w_p0_wins = r_last_p1;
`else
  assign w_p0_wins = 1'b1;
`endif

  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (!reset) begin
      if (r_state == S_LOCK1) begin
        p1_gnt = p1_req;
      end else if (p0_req && p1_req) begin
        p0_gnt = w_p0_wins;
        p1_gnt = !w_p0_wins;
      end else begin
        p0_gnt = p0_req;
        p1_gnt = p1_req;
      end
    end
  end

  always_comb begin
    w_next_state = S_IDLE;
    case (r_state)
      S_LOCK1: w_next_state = p1_lock ? S_LOCK1 : S_IDLE;
      default: begin
        if (p1_gnt && p1_lock) begin
          w_next_state = S_LOCK1;
        end else if (p0_req || p1_req) begin
          w_next_state = S_SHARED;
        end else begin
          w_next_state = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  assign mem_en    = p0_gnt | p1_gnt;
  assign mem_we    = (p0_gnt & p0_we) | (p1_gnt & p1_we);
  assign mem_addr  = p1_gnt ? p1_addr : p0_addr;
  assign mem_wdata = p1_gnt ? p1_wdata : p0_wdata;

  // rvalid is masked by reset so a read in flight when reset arrives is never delivered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_p0_rd_pend <= 1'b0;
      r_p1_rd_pend <= 1'b0;
      r_p0_rdata   <= '0;
      r_p1_rdata   <= '0;
    end else begin
      r_p0_rd_pend <= p0_gnt & ~p0_we;
      r_p1_rd_pend <= p1_gnt & ~p1_we;
      if (w_p0_rvalid) r_p0_rdata <= mem_rdata;
      if (w_p1_rvalid) r_p1_rdata <= mem_rdata;
    end
  end

  assign w_p0_rvalid = r_p0_rd_pend & ~reset;
  assign w_p1_rvalid = r_p1_rd_pend & ~reset;
  assign p0_rvalid   = w_p0_rvalid;
  assign p1_rvalid   = w_p1_rvalid;
  assign p0_rdata    = w_p0_rvalid ? mem_rdata : r_p0_rdata;
  assign p1_rdata    = w_p1_rvalid ? mem_rdata : r_p1_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic against a behavioural model.
// Honours MEM_ARB_ROUND_ROBIN_EN the same way the design does.
module tb_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 16;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit ROUND_ROBIN = 1'b1;
`else
  localparam bit ROUND_ROBIN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          p0_req = 1'b0, p0_we = 1'b0;
  logic [AW-1:0] p0_addr = '0;
  logic [DW-1:0] p0_wdata = '0;
  logic          p0_gnt, p0_rvalid;
  logic [DW-1:0] p0_rdata;
  logic          p1_req = 1'b0, p1_we = 1'b0, p1_lock = 1'b0;
  logic [AW-1:0] p1_addr = '0;
  logic [DW-1:0] p1_wdata = '0;
  logic          p1_gnt, p1_rvalid;
  logic [DW-1:0] p1_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_lock(p1_lock), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] init_word(input int i);
    logic [7:0] b;
    b = i[7:0];
    return (i == 5) ? 16'hA5A5 : {b ^ 8'h3C, b};
  endfunction

  // Synchronous memory: read data appears the cycle after the strobe.
  logic [DW-1:0] mem [256];
  bit mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  // Behavioural model: ownership flag, last winner, shadow memory, pending read per port.
  logic [DW-1:0] ref_mem [256];
  bit ref_ready = 1'b0;
  bit m_locked = 1'b0, m_last1 = 1'b1;
  bit m_pend0 = 1'b0, m_pend1 = 1'b0;
  logic [DW-1:0] m_pd0 = '0, m_pd1 = '0, m_hold0 = '0, m_hold1 = '0;
  bit eg0 = 1'b0, eg1 = 1'b0;

  always @(negedge clk) begin
    bit rv0, rv1, p0wins;
    logic [DW-1:0] erd0, erd1;
    if (!ref_ready) begin
      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
      ref_ready = 1'b1;
    end
    eg0 = 1'b0;
    eg1 = 1'b0;
    if (!reset) begin
      if (m_locked) begin
        eg1 = p1_req;
      end else if (p0_req && p1_req) begin
        p0wins = ROUND_ROBIN ? m_last1 : 1'b1;
        eg0 = p0wins;
        eg1 = !p0wins;
      end else begin
        eg0 = p0_req;
        eg1 = p1_req;
      end
    end
    rv0  = m_pend0 && !reset;
    rv1  = m_pend1 && !reset;
    erd0 = rv0 ? m_pd0 : m_hold0;
    erd1 = rv1 ? m_pd1 : m_hold1;

    cmp("p0_gnt", p0_gnt, eg0);
    cmp("p1_gnt", p1_gnt, eg1);
    cmp("mem_en", mem_en, eg0 | eg1);
    cmp("mem_we", mem_we, (eg0 & p0_we) | (eg1 & p1_we));
    if (eg0 || eg1) begin
      cmp("mem_addr", mem_addr, eg0 ? p0_addr : p1_addr);
      cmp("mem_wdata", mem_wdata, eg0 ? p0_wdata : p1_wdata);
    end
    cmp("p0_rvalid", p0_rvalid, rv0);
    cmp("p1_rvalid", p1_rvalid, rv1);
    cmp("p0_rdata", p0_rdata, erd0);
    cmp("p1_rdata", p1_rdata, erd1);

    if (reset) begin
      m_locked = 1'b0; m_last1 = 1'b1;
      m_pend0 = 1'b0; m_pend1 = 1'b0;
      m_hold0 = '0; m_hold1 = '0;
    end else begin
      if (rv0) m_hold0 = m_pd0;
      if (rv1) m_hold1 = m_pd1;
      m_pend0 = eg0 && !p0_we;
      m_pend1 = eg1 && !p1_we;
      if (m_pend0) m_pd0 = ref_mem[p0_addr];
      if (m_pend1) m_pd1 = ref_mem[p1_addr];
      if (eg0 && p0_we) ref_mem[p0_addr] = p0_wdata;
      if (eg1 && p1_we) ref_mem[p1_addr] = p1_wdata;
      if (eg0 || eg1) m_last1 = eg1;
      m_locked = m_locked ? p1_lock : (eg1 && p1_lock);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] seq, seq_exp;
    bit act0, act1;
    int wait0, wait1, maxw, ngrants;

    // Reset state: requests are ignored while reset is high.
    tick(); tick();
    p0_req = 1'b1; p1_req = 1'b1;
    #1;
    cmp("reset_p0_gnt", p0_gnt, 0);
    cmp("reset_p1_gnt", p1_gnt, 0);
    cmp("reset_mem_en", mem_en, 0);
    cmp("reset_p0_rvalid", p0_rvalid, 0);
    cmp("reset_p0_rdata", p0_rdata, 0);
    tick();
    reset = 1'b0; p0_req = 1'b0; p1_req = 1'b0;
    tick();

    // Single p0 read of a preloaded word.
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 8'h05;
    #1;
    cmp("rd05_gnt", p0_gnt, 1);
    cmp("rd05_mem_addr", mem_addr, 8'h05);
    tick();
    p0_req = 1'b0;
    #1;
    cmp("rd05_rvalid", p0_rvalid, 1);
    cmp("rd05_rdata", p0_rdata, 16'hA5A5);
    cmp("rd05_p1_rvalid", p1_rvalid, 0);
    tick();
    cmp("rd05_hold", p0_rdata, 16'hA5A5);

    // p1 write then p0 readback.
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 8'h10; p1_wdata = 16'h1234;
    #1;
    cmp("wr10_gnt", p1_gnt, 1);
    tick();
    p1_req = 1'b0; p1_we = 1'b0;
    #1;
    cmp("wr10_no_rvalid", p1_rvalid, 0);
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 8'h10;
    tick();
    p0_req = 1'b0;
    #1;
    cmp("rd10_rvalid", p0_rvalid, 1);
    cmp("rd10_rdata", p0_rdata, 16'h1234);
    tick();

    // Continuous contention for four reads after a fresh reset.
    reset = 1'b1; tick(); reset = 1'b0; tick();
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 8'h20;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 8'h30;
    seq = '0;
    for (int i = 0; i < 4; i++) begin
      #1;
      seq[i] = p1_gnt;
      cmp("contend_one_gnt", p0_gnt ^ p1_gnt, 1);
      tick();
    end
    seq_exp = ROUND_ROBIN ? 4'b1010 : 4'b0000;
    cmp("contend_order", seq, seq_exp);
    p0_req = 1'b0;
    #1;
    cmp("contend_p1_after_p0_drop", p1_gnt, 1);
    tick();
    p1_req = 1'b0;
    tick();

    // Locked burst from p1 while p0 keeps asking.
    p1_req = 1'b1; p1_we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      p1_addr = 8'(i); p1_wdata = 16'hBEE0 + 16'(i); p1_lock = (i < 3);
      if (i > 0) begin p0_req = 1'b1; p0_we = 1'b0; p0_addr = 8'h05; end
      #1;
      cmp("lock_p0_blocked", p0_gnt, 0);
      cmp("lock_p1_gnt", p1_gnt, 1);
      tick();
    end
    p1_req = 1'b0; p1_we = 1'b0; p1_lock = 1'b0;
    #1;
    cmp("unlock_p0_gnt", p0_gnt, 1);
    tick();
    p0_req = 1'b0;
    tick();

    // Reset arriving while a read is in flight.
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 8'h03;
    #1;
    cmp("rst_rd_gnt", p0_gnt, 1);
    tick();
    reset = 1'b1; p0_req = 1'b0;
    #1;
    cmp("rst_rd_rvalid_during", p0_rvalid, 0);
    tick();
    reset = 1'b0;
    #1;
    cmp("rst_rd_rvalid_after", p0_rvalid, 0);
    cmp("rst_rd_rdata_after", p0_rdata, 0);
    tick();

    // Random traffic; the negedge model checks every cycle.
    act0 = 1'b0; act1 = 1'b0; wait0 = 0; wait1 = 0; maxw = 0; ngrants = 0;
    for (int c = 0; c < 800; c++) begin
      if (act0) begin
        if (eg0) begin
          act0 = 1'b0; p0_req = 1'b0; ngrants++;
          if (wait0 > maxw) maxw = wait0;
        end else wait0++;
      end else if ($urandom_range(0, 99) < 60) begin
        act0 = 1'b1; wait0 = 0; p0_req = 1'b1;
        p0_we = 1'($urandom_range(0, 1));
        p0_addr = 8'($urandom_range(0, 15));
        p0_wdata = 16'($urandom);
      end
      if (act1) begin
        if (eg1) begin
          act1 = 1'b0; p1_req = 1'b0; p1_lock = 1'b0; ngrants++;
          if (wait1 > maxw) maxw = wait1;
        end else wait1++;
      end else if ($urandom_range(0, 99) < 50) begin
        act1 = 1'b1; wait1 = 0; p1_req = 1'b1;
        p1_we = 1'($urandom_range(0, 1));
        p1_addr = 8'($urandom_range(0, 15));
        p1_wdata = 16'($urandom);
        p1_lock = ($urandom_range(0, 3) == 0);
      end
      reset = ($urandom_range(0, 199) == 0);
      tick();
    end
    cmp("random_max_wait_bounded", (maxw <= 20), 1);
    cmp("random_activity", (ngrants > 200), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
